// File: rtl/mod_counter_cascade_pkg.sv
// Shared definitions for the cascaded modulo counter: parameter limits,
// the per-digit width function and the count-direction type.
package mod_counter_cascade_pkg;

  // Supported parameter ranges for the counter.
  localparam int unsigned DIGITS_MIN = 1;
  localparam int unsigned DIGITS_MAX = 8;
  localparam int unsigned MOD_MIN    = 2;
  localparam int unsigned MOD_MAX    = 16;

  // Count direction as carried on the up input.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Bits needed to hold values 0..modulus-1; never less than one bit.
  function automatic int unsigned digit_width(input int unsigned modulus);
    if (modulus <= 2) begin
      return 1;
    end
    return $clog2(modulus);
  endfunction

endpackage

// File: rtl/mod_counter_cascade_digit.sv
// Single modulo-MOD counter digit. Priority inside the digit is
// clear > load > step > hold. The terminal flag reports the value at which
// the next step in the current direction wraps, and range_err flags a load
// value that does not fit the modulus.
module mod_digit
  import mod_counter_cascade_pkg::*;
#(
  parameter int unsigned MOD = 10,
  parameter int unsigned W   = digit_width(MOD)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] din_i,
  input  logic         step_i,
  input  logic         up_i,
  output logic [W-1:0] value_o,
  output logic         terminal_o,
  output logic         range_err_o
);

  // Largest legal digit value, and the modulus widened by one bit so that a
  // power-of-two modulus still compares correctly against a W-bit load value.
  localparam logic [W-1:0] MAX_V = W'(MOD - 1);
  localparam logic [W:0]   MOD_V = (W + 1)'(MOD);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;
  dir_e         dir;

  assign dir         = dir_e'(up_i);
  assign terminal_o  = (dir == DIR_UP) ? (value_q == MAX_V) : (value_q == '0);
  assign range_err_o = ({1'b0, din_i} >= MOD_V);
  assign value_o     = value_q;

  // Next digit value: clear, sanitised load, wrapping step, or hold.
  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (load_i) begin
      value_d = range_err_o ? '0 : din_i;
    end else if (step_i) begin
      if (dir == DIR_UP) begin
        value_d = (value_q == MAX_V) ? '0 : value_q + 1'b1;
      end else begin
        value_d = (value_q == '0) ? MAX_V : value_q - 1'b1;
      end
    end
  end

  // Digit state register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/mod_counter_cascade.sv
// Cascaded modulo counter: DIGITS digits of modulus MOD with a combinational
// carry chain, so every digit updates on the same edge. rco is the
// 74x160-style ripple carry, gated by ent, for chaining instances.
module mod_counter_cascade
  import mod_counter_cascade_pkg::*;
#(
  parameter  int unsigned DIGITS = 2,
  parameter  int unsigned MOD    = 10,
  localparam int unsigned W      = digit_width(MOD)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                load,
  input  logic [DIGITS*W-1:0] din,
  input  logic                enp,
  input  logic                ent,
  input  logic                up,
  output logic [DIGITS*W-1:0] q,
  output logic                rco,
  output logic                err
);

  // chain[k] is high when every digit below k is terminal; chain[DIGITS]
  // covers the whole counter.
  logic [DIGITS:0]   chain;
  logic [DIGITS-1:0] term;
  logic [DIGITS-1:0] range_err;
  logic              count_en;
  logic              err_q;
  logic              err_d;

  assign count_en = enp & ent & ~clr & ~load;
  assign chain[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    assign chain[k+1] = chain[k] & term[k];

    mod_digit #(
      .MOD (MOD),
      .W   (W)
    ) u_digit (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (clr),
      .load_i      (load),
      .din_i       (din[k*W +: W]),
      .step_i      (count_en & chain[k]),
      .up_i        (up),
      .value_o     (q[k*W +: W]),
      .terminal_o  (term[k]),
      .range_err_o (range_err[k])
    );
  end

  assign rco = ent & chain[DIGITS];
  assign err = err_q;

  // A load that is not overridden by clear flags any out-of-range digit.
  always_comb begin
    err_d = 1'b0;
    if (!clr && load) begin
      err_d = |range_err;
    end
  end

  // Error flag register: one-cycle pulse following a bad load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_mod_counter_cascade.sv
// Directed testbench for mod_counter_cascade (DIGITS=2, MOD=10), plus a
// two-instance cascade chained through rco -> ent.
module tb_mod_counter_cascade;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       load;
  logic [7:0] din;
  logic       enp;
  logic       ent;
  logic       up;
  logic [7:0] q;
  logic       rco;
  logic       err;

  logic [7:0] q_lo;
  logic [7:0] q_hi;
  logic       rco_lo;
  logic       rco_hi;
  logic       err_lo;
  logic       err_hi;

  int n_tests;
  int n_fail;

  mod_counter_cascade #(.DIGITS(2), .MOD(10)) dut (
    .clk (clk), .rst_n (rst_n), .clr (clr), .load (load), .din (din),
    .enp (enp), .ent (ent), .up (up), .q (q), .rco (rco), .err (err)
  );

  mod_counter_cascade #(.DIGITS(2), .MOD(10)) u_lo (
    .clk (clk), .rst_n (rst_n), .clr (clr), .load (load), .din (din),
    .enp (enp), .ent (ent), .up (up), .q (q_lo), .rco (rco_lo), .err (err_lo)
  );

  mod_counter_cascade #(.DIGITS(2), .MOD(10)) u_hi (
    .clk (clk), .rst_n (rst_n), .clr (clr), .load (load), .din (din),
    .enp (enp), .ent (rco_lo), .up (up), .q (q_hi), .rco (rco_hi), .err (err_hi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd2(input int n);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'((n / 10) % 10);
    o = 4'(n % 10);
    return {t, o};
  endfunction

  function automatic logic [15:0] bcd4(input int n);
    return {bcd2((n / 100) % 100), bcd2(n % 100)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; din = 8'h00;
    enp = 1'b0; ent = 1'b0; up = 1'b0;
    #3;
    n_tests++; if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q got %h expected 00", q); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b expected 0", err); end
    ent = 1'b1; #1;
    n_tests++; if (rco !== 1'b1) begin n_fail++; $display("FAIL reset_rco_down got %b expected 1", rco); end
    @(negedge clk); rst_n = 1'b1;
    // bring the counter to 37 and reset mid-count
    load = 1'b1; din = 8'h36; tick();
    load = 1'b0; enp = 1'b1; ent = 1'b1; up = 1'b1; tick();
    n_tests++; if (q !== 8'h37) begin n_fail++; $display("FAIL pre_reset_q got %h expected 37", q); end
    #2; rst_n = 1'b0; #1;
    n_tests++; if (q !== 8'h00) begin n_fail++; $display("FAIL midcount_reset_q got %h expected 00", q); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL midcount_reset_err got %b expected 0", err); end
    n_tests++; if (rco !== 1'b0) begin n_fail++; $display("FAIL reset_rco_up got %b expected 0", rco); end
    up = 1'b0; #1;
    n_tests++; if (rco !== 1'b1) begin n_fail++; $display("FAIL reset_rco_ent1 got %b expected 1", rco); end
    ent = 1'b0; #1;
    n_tests++; if (rco !== 1'b0) begin n_fail++; $display("FAIL reset_rco_ent0 got %b expected 0", rco); end
    // release and count on the very first edge
    ent = 1'b1; up = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    tick();
    n_tests++; if (q !== 8'h01) begin n_fail++; $display("FAIL post_reset_first_edge got %h expected 01", q); end
    // reset mid-load aborts the load and the error pulse
    enp = 1'b0; load = 1'b1; din = 8'h4C; tick();
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL pre_reset_err got %b expected 1", err); end
    #2; rst_n = 1'b0; #1;
    n_tests++; if (q !== 8'h00 || err !== 1'b0) begin n_fail++; $display("FAIL midload_reset got q=%h err=%b expected q=00 err=0", q, err); end
    load = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_up_count();
    clr = 1'b1; tick(); clr = 1'b0;
    enp = 1'b1; ent = 1'b1; up = 1'b1; #1;
    for (int i = 1; i <= 100; i++) begin
      n_tests++;
      if (rco !== (((i - 1) % 100) == 99)) begin
        n_fail++; $display("FAIL up_rco at count %0d got %b", (i - 1) % 100, rco);
      end
      tick();
      n_tests++;
      if (q !== bcd2(i % 100)) begin
        n_fail++; $display("FAIL up_q step %0d got %h expected %h", i, q, bcd2(i % 100));
      end
    end
  endtask

  task automatic test_down_count();
    enp = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    enp = 1'b1; ent = 1'b1; up = 1'b0; #1;
    n_tests++; if (rco !== 1'b1) begin n_fail++; $display("FAIL down_rco_00 got %b expected 1", rco); end
    tick();
    n_tests++; if (q !== 8'h99) begin n_fail++; $display("FAIL down_wrap got %h expected 99", q); end
    n_tests++; if (rco !== 1'b0) begin n_fail++; $display("FAIL down_rco_99 got %b expected 0", rco); end
    tick();
    n_tests++; if (q !== 8'h98) begin n_fail++; $display("FAIL down_98 got %h expected 98", q); end
    tick();
    n_tests++; if (q !== 8'h97) begin n_fail++; $display("FAIL down_97 got %h expected 97", q); end
  endtask

  task automatic test_priority();
    clr = 1'b1; load = 1'b1; din = 8'h45; enp = 1'b1; ent = 1'b1; tick();
    n_tests++; if (q !== 8'h00 || err !== 1'b0) begin n_fail++; $display("FAIL prio_clr got q=%h err=%b expected q=00 err=0", q, err); end
    clr = 1'b0; enp = 1'b0; ent = 1'b0; tick();
    n_tests++; if (q !== 8'h45) begin n_fail++; $display("FAIL prio_load got %h expected 45", q); end
    // load beats count
    din = 8'h12; enp = 1'b1; ent = 1'b1; up = 1'b1; tick();
    n_tests++; if (q !== 8'h12) begin n_fail++; $display("FAIL prio_load_over_count got %h expected 12", q); end
    load = 1'b0; enp = 1'b0; ent = 1'b0;
  endtask

  task automatic test_range_err();
    load = 1'b1; din = 8'h4C; tick();
    n_tests++; if (q !== 8'h40) begin n_fail++; $display("FAIL oor_low_q got %h expected 40", q); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_low_err got %b expected 1", err); end
    load = 1'b0; tick();
    n_tests++; if (err !== 1'b0 || q !== 8'h40) begin n_fail++; $display("FAIL oor_clear got q=%h err=%b expected q=40 err=0", q, err); end
    load = 1'b1; din = 8'hA3; tick();
    n_tests++; if (q !== 8'h03 || err !== 1'b1) begin n_fail++; $display("FAIL oor_high got q=%h err=%b expected q=03 err=1", q, err); end
    din = 8'h58; tick();
    n_tests++; if (q !== 8'h58 || err !== 1'b0) begin n_fail++; $display("FAIL good_load got q=%h err=%b expected q=58 err=0", q, err); end
    clr = 1'b1; din = 8'hFF; tick();
    n_tests++; if (q !== 8'h00 || err !== 1'b0) begin n_fail++; $display("FAIL clr_masks_err got q=%h err=%b expected q=00 err=0", q, err); end
    clr = 1'b0; load = 1'b0;
  endtask

  task automatic test_enables();
    load = 1'b1; din = 8'h99; tick(); load = 1'b0;
    enp = 1'b0; ent = 1'b1; up = 1'b1; #1;
    n_tests++; if (rco !== 1'b1) begin n_fail++; $display("FAIL enp0_rco got %b expected 1", rco); end
    tick();
    n_tests++; if (q !== 8'h99) begin n_fail++; $display("FAIL enp0_hold got %h expected 99", q); end
    enp = 1'b1; ent = 1'b0; #1;
    n_tests++; if (rco !== 1'b0) begin n_fail++; $display("FAIL ent0_rco got %b expected 0", rco); end
    tick();
    n_tests++; if (q !== 8'h99) begin n_fail++; $display("FAIL ent0_hold got %h expected 99", q); end
    ent = 1'b1; tick();
    n_tests++; if (q !== 8'h00) begin n_fail++; $display("FAIL full_wrap_up got %h expected 00", q); end
    up = 1'b0; #1;
    n_tests++; if (rco !== 1'b1) begin n_fail++; $display("FAIL dir_change_rco got %b expected 1", rco); end
    tick();
    n_tests++; if (q !== 8'h99) begin n_fail++; $display("FAIL full_wrap_down got %h expected 99", q); end
  endtask

  task automatic test_back_to_back();
    enp = 1'b0; load = 1'b1; din = 8'h50; tick(); load = 1'b0;
    enp = 1'b1; ent = 1'b1; up = 1'b1; tick();
    n_tests++; if (q !== 8'h51) begin n_fail++; $display("FAIL b2b_up got %h expected 51", q); end
    up = 1'b0; tick();
    n_tests++; if (q !== 8'h50) begin n_fail++; $display("FAIL b2b_down1 got %h expected 50", q); end
    tick();
    n_tests++; if (q !== 8'h49) begin n_fail++; $display("FAIL b2b_down2 got %h expected 49", q); end
    up = 1'b1; tick();
    n_tests++; if (q !== 8'h50) begin n_fail++; $display("FAIL b2b_up2 got %h expected 50", q); end
  endtask

  task automatic test_cascade();
    enp = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    enp = 1'b1; ent = 1'b1; up = 1'b1; #1;
    n_tests++; if ({q_hi, q_lo} !== 16'h0000) begin n_fail++; $display("FAIL casc_start got %h expected 0000", {q_hi, q_lo}); end
    for (int i = 1; i <= 10000; i++) begin
      tick();
      n_tests++;
      if ({q_hi, q_lo} !== bcd4(i % 10000)) begin
        n_fail++; $display("FAIL casc_q step %0d got %h expected %h", i, {q_hi, q_lo}, bcd4(i % 10000));
      end
      n_tests++;
      if (rco_hi !== ((i % 10000) == 9999)) begin
        n_fail++; $display("FAIL casc_rco step %0d got %b", i, rco_hi);
      end
    end
    enp = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_up_count();
    test_down_count();
    test_priority();
    test_range_err();
    test_enables();
    test_back_to_back();
    test_cascade();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
